// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the segmented pipelined adder/subtractor.
// Holds the operation encoding and the segment-count helper.
// Imported by the interface, the top and the testbench.
package adder_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of carry-chain segments, which is also the number of add stages.
  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result stream bundle for adder_pipe.
// Input side: in_valid/in_ready with x, y, carry_in, op (plus sat when ADDER_PIPE_SAT_EN).
// Output side: out_valid/out_ready with sum, carry_out. master = producer/consumer, slave = adder.
interface adder_pipe_if import adder_pipe_pkg::*; #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  op_e              op;
`ifdef ADDER_PIPE_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

`ifdef ADDER_PIPE_SAT_EN
  modport master (
    output in_valid, x, y, carry_in, op, sat, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );
  modport slave (
    input  in_valid, x, y, carry_in, op, sat, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
`else
  modport master (
    output in_valid, x, y, carry_in, op, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );
  modport slave (
    input  in_valid, x, y, carry_in, op, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
`endif

endinterface

// File: rtl/adder_pipe_seg.sv
// One SEG_W-bit slice of the carry chain: adds a segment and registers sum, carry and valid.
// Latency: 1 cycle.
// Backpressure: hold_i freezes valid and data registers.
// Ports: clk, rst_n, hold_i, vld_i, a_i, b_i, cin_i -> vld_o, sum_o, cout_o (all registered).
module adder_pipe_seg #(
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             vld_i,
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic             vld_o,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o
);

  logic [SEG_W:0]   add_d;
  logic             vld_q;
  logic [SEG_W-1:0] sum_q;
  logic             cout_q;

  assign add_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (!hold_i) begin
      vld_q  <= vld_i;
      sum_q  <= add_d[SEG_W-1:0];
      cout_q <= add_d[SEG_W];
    end
  end

  assign vld_o  = vld_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, one SEG_W-bit carry segment per stage (optional saturation: ADDER_PIPE_SAT_EN).
// Latency: NSEG cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: out_valid && !out_ready stalls every stage in place; in_ready = !stall.
// Ports: clk, rst_n (async, active-low), bus (adder_pipe_if.slave: operand stream in, result stream out).
module adder_pipe import adder_pipe_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_pipe_if.slave  bus
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  generate
    if (WIDTH < 2 || SEG_W < 1 || SEG_W > WIDTH || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
      $error("adder_pipe: WIDTH must be >= 2 and a multiple of SEG_W, with SEG_W <= WIDTH");
    end
  endgenerate

  logic stall;
  assign stall = bus.out_valid && !bus.out_ready;

  // Stage 0 holds the captured beat; B is stored already inverted for subtract.
  logic             vld0_q;
  logic             cin0_q;
  // Operands travel only as far as the last stage that still needs them.
  logic [WIDTH-1:0] a_q [0:NSEG-1];
  logic [WIDTH-1:0] b_q [0:NSEG-1];
  // Finished low sum bits entering each stage (segment region of stage k is zero).
  logic [WIDTH-1:0] s_q [1:NSEG];
`ifdef ADDER_PIPE_SAT_EN
  op_e              op_q  [0:NSEG];
  logic             sat_q [0:NSEG];
`endif

  logic             v_arr  [0:NSEG];
  logic             c_arr  [0:NSEG];
  logic [WIDTH-1:0] s_full [0:NSEG];
  logic [SEG_W-1:0] seg_s  [1:NSEG];

  assign v_arr[0]  = vld0_q;
  assign c_arr[0]  = cin0_q;
  assign s_full[0] = '0;

  generate
    for (genvar k = 1; k <= NSEG; k++) begin : g_seg
      adder_pipe_seg #(.SEG_W(SEG_W)) u_seg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (stall),
        .vld_i  (v_arr[k-1]),
        .a_i    (a_q[k-1][(k-1)*SEG_W +: SEG_W]),
        .b_i    (b_q[k-1][(k-1)*SEG_W +: SEG_W]),
        .cin_i  (c_arr[k-1]),
        .vld_o  (v_arr[k]),
        .sum_o  (seg_s[k]),
        .cout_o (c_arr[k])
      );
      // Merge the segment just computed into the finished low bits.
      assign s_full[k] = s_q[k] | (WIDTH'(seg_s[k]) << ((k-1)*SEG_W));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q <= 1'b0;
      cin0_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= NSEG; k++) begin
        s_q[k] <= '0;
      end
`ifdef ADDER_PIPE_SAT_EN
      for (int k = 0; k <= NSEG; k++) begin
        op_q[k]  <= OP_ADD;
        sat_q[k] <= 1'b0;
      end
`endif
    end else if (!stall) begin
      vld0_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_q[0] <= bus.x;
        b_q[0] <= (bus.op == OP_SUB) ? ~bus.y : bus.y;
        cin0_q <= bus.carry_in;
`ifdef ADDER_PIPE_SAT_EN
        op_q[0]  <= bus.op;
        sat_q[0] <= bus.sat;
`endif
      end
      for (int k = 1; k < NSEG; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= NSEG; k++) begin
        s_q[k] <= s_full[k-1];
`ifdef ADDER_PIPE_SAT_EN
        op_q[k]  <= op_q[k-1];
        sat_q[k] <= sat_q[k-1];
`endif
      end
    end
  end

  // Output value is derived purely from registers, so it is stable while stalled.
  logic [WIDTH-1:0] sum_res;
  always_comb begin
    sum_res = s_full[NSEG];
`ifdef ADDER_PIPE_SAT_EN
    if (sat_q[NSEG]) begin
      if (op_q[NSEG] == OP_ADD && c_arr[NSEG]) begin
        sum_res = '1;
      end else if (op_q[NSEG] == OP_SUB && !c_arr[NSEG]) begin
        sum_res = '0;  // carry_out=0 on subtract means a borrow occurred
      end
    end
`endif
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = v_arr[NSEG];
  assign bus.sum       = sum_res;
  assign bus.carry_out = c_arr[NSEG];

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits (>= 2).
REQ-002 Parameter SEG_W, default 4, carry-chain segment width; NSEG = WIDTH/SEG_W.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operand beat present.
REQ-006 Port in_ready  output  1  block accepts beat this cycle.
REQ-007 Port x  input  WIDTH  operand A.
REQ-008 Port y  input  WIDTH  operand B.
REQ-009 Port carry_in  input  1  carry into bit 0.
REQ-010 Port op  input  1  0 = add, 1 = subtract (op_e).
REQ-011 Port out_valid  output  1  result beat present.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.
REQ-013 Port sum  output  WIDTH  result.
REQ-014 Port carry_out  output  1  raw carry out of bit WIDTH-1.

Function
REQ-015 Beat accepted on rising edge with in_valid && in_ready; x, y, carry_in, op captured into stage-0 registers.
REQ-016 op=1: operand B replaced by ~y; result = x + ~y + carry_in (caller drives carry_in=1 for plain x-y).
REQ-017 Stage k (1..NSEG) adds segment k-1 (bits k*SEG_W-1 : (k-1)*SEG_W) using carry registered by stage k-1; lower finished bits and upper unprocessed operand bits travel with the beat.
REQ-018 Latency: out_valid rises NSEG edges after acceptance edge when unstalled (default config: 2).
REQ-019 Throughput one beat per cycle while out_ready=1; beats delivered in acceptance order, none dropped or duplicated.
REQ-020 Stall = out_valid && !out_ready; during stall every stage (valid and data) holds; in_ready = !stall.
REQ-021 sum and carry_out stable while out_valid && !out_ready.
REQ-022 Bubbles propagate as invalid stages; no bubble compaction required.
REQ-023 carry_out for subtract = 1 means no borrow.
REQ-024 WIDTH not a multiple of SEG_W, or SEG_W > WIDTH, is an elaboration-time error.

Reset
REQ-025 rst_n low: all stage valid bits, out_valid, sum, carry_out, and data registers cleared to 0 immediately.
REQ-026 in_ready = 1 out of reset; in-flight beats at reset assertion are discarded, never emitted.

Configuration
REQ-027 Macro ADDER_PIPE_SAT_EN: when defined, 1-bit input port sat exists, captured with the beat.
REQ-028 With macro and sat=1: add with carry_out=1 gives sum all-ones; subtract with carry_out=0 gives sum 0; carry_out still raw.
REQ-029 Without macro: no sat port, no saturation logic; sum always wraps modulo 2^WIDTH.

Structure
REQ-030 Package adder_pipe_pkg holds op_e enum (OP_ADD=0, OP_SUB=1) and function computing NSEG.
REQ-031 One sub-module adder_pipe_seg: single SEG_W-bit add stage with registered carry, valid, and hold input, instantiated NSEG times by generate loop.

Verification
REQ-032 Default cfg, add x=8'hFF y=8'h01 cin=0 -> 2 cycles later sum=8'h00 carry_out=1.
REQ-033 Sub x=8'h10 y=8'h01 cin=1 -> sum=8'h0F carry_out=1; sub x=8'h00 y=8'h01 cin=1 -> sum=8'hFF carry_out=0.
REQ-034 Four back-to-back beats, out_ready=0 for 3 cycles -> in_ready=0 during stall, sum held, all four results emitted in order.
REQ-035 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no result emitted after release, in_ready=1.
REQ-036 ADDER_PIPE_SAT_EN, sat=1: add 8'hFF+8'h01 -> sum=8'hFF carry_out=1; sub 8'h00-8'h01 (cin=1) -> sum=8'h00 carry_out=0.
REQ-037 WIDTH=32 SEG_W=8: latency 4, 1000 random add/sub beats with random out_ready match reference model.
